// File: rtl/pipe_adder.sv
// pipe_adder: chunk-pipelined add/subtract with carry, overflow and zero flags, valid/ready flow control
module pipe_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK_W = 8,
   localparam int STAGES = WIDTH / CHUNK_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o
);
   logic adv, cin;
   logic [WIDTH-1:0] b_eff;
   assign adv = !out_valid_o || out_ready_i;
   assign in_ready_o = adv;
   assign b_eff = sub_i ? ~b_i : b_i;
   assign cin = sub_i | carry_i;
   if (WIDTH % CHUNK_W != 0) begin : g_bad
      $error("pipe_adder: WIDTH must be a multiple of CHUNK_W");
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int REM = WIDTH - k * CHUNK_W;
      logic [REM-1:0] a_in, b_in;
      logic c_in, v_in, am_in, bm_in, c_q, v_q, am_q, bm_q;
      logic [CHUNK_W:0] t;
      logic [(k+1)*CHUNK_W-1:0] s_n, s_q;
      if (k == 0) begin : g_src
         assign a_in = a_i;
         assign b_in = b_eff;
         assign c_in = cin;
         assign v_in = in_valid_i;
         assign am_in = a_i[WIDTH-1];
         assign bm_in = b_eff[WIDTH-1];
         assign s_n = t[CHUNK_W-1:0];
      end else begin : g_src
         assign a_in = g_st[k-1].g_sk.a_q;
         assign b_in = g_st[k-1].g_sk.b_q;
         assign c_in = g_st[k-1].c_q;
         assign v_in = g_st[k-1].v_q;
         assign am_in = g_st[k-1].am_q;
         assign bm_in = g_st[k-1].bm_q;
         assign s_n = {t[CHUNK_W-1:0], g_st[k-1].s_q};
      end
      assign t = {1'b0, a_in[CHUNK_W-1:0]} + {1'b0, b_in[CHUNK_W-1:0]} + {{CHUNK_W{1'b0}}, c_in};
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
            am_q <= 1'b0;
            bm_q <= 1'b0;
         end else if (adv) begin
            s_q <= s_n;
            c_q <= t[CHUNK_W];
            v_q <= v_in;
            am_q <= am_in;
            bm_q <= bm_in;
         end
      end
      // operand bits still waiting for later stages
      if (k < STAGES - 1) begin : g_sk
         logic [REM-CHUNK_W-1:0] a_q, b_q;
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_in[REM-1:CHUNK_W];
               b_q <= b_in[REM-1:CHUNK_W];
            end
         end
      end
   end
   assign out_valid_o = g_st[STAGES-1].v_q;
   assign sum_o = g_st[STAGES-1].s_q;
   assign carry_o = g_st[STAGES-1].c_q;
   assign overflow_o = (g_st[STAGES-1].am_q == g_st[STAGES-1].bm_q) && (sum_o[WIDTH-1] != g_st[STAGES-1].am_q);
   assign zero_o = out_valid_o && ~|sum_o;
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and random checks of pipe_adder against an arithmetic reference model
module tb_pipe_adder;
   localparam int W = 32;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0, out_valid, out_ready = 1'b1, co, ov, zero;
   logic [W-1:0] a = '0, b = '0, sum;
   int n_chk = 0, n_err = 0, cyc = 0;
   logic [34:0] q[$];
   logic sv_valid = 1'b0, s_c = 1'b0, s_s = 1'b0;
   logic [W-1:0] s_a = '0, s_b = '0;
   logic sw_rdy[3], sw_vld[3], sw_co[3], sw_ov[3], sw_zero[3];
   logic [W-1:0] sw_sum[3];
   bit hv[1024];
   logic [34:0] he[1024];
   bit sev;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipe_adder #(.WIDTH(W), .CHUNK_W(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .carry_i(cin), .sub_i(sub),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum),
      .carry_o(co), .overflow_o(ov), .zero_o(zero)
   );

   for (genvar i = 0; i < 3; i++) begin : g_sw
      pipe_adder #(.WIDTH(W), .CHUNK_W(i == 0 ? 1 : i == 1 ? 4 : 32)) sw (
         .clk_i(clk), .rst_ni(rst_n), .in_valid_i(sv_valid), .in_ready_o(sw_rdy[i]),
         .a_i(s_a), .b_i(s_b), .carry_i(s_c), .sub_i(s_s),
         .out_valid_o(sw_vld[i]), .out_ready_i(1'b1), .sum_o(sw_sum[i]),
         .carry_o(sw_co[i]), .overflow_o(sw_ov[i]), .zero_o(sw_zero[i])
      );
   end

   function automatic int lat(input int i);
      return i == 0 ? 32 : i == 1 ? 8 : 1;
   endfunction

   // {carry, overflow, zero, sum} from plain signed/unsigned arithmetic
   function automatic logic [34:0] ref_add(input logic [31:0] x, y, input logic c, s);
      longint r;
      logic [32:0] u;
      logic [31:0] lo;
      r = s ? longint'($signed(x)) - longint'($signed(y))
            : longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      u = {1'b0, x} + {1'b0, y} + {32'b0, c};
      lo = r[31:0];
      return {s ? x >= y : u[32], r > 64'sd2147483647 || r < -64'sd2147483648, lo == 32'h0, lo};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic run_one(input string nm, input logic [31:0] x, y, input logic c, s, input logic [34:0] exp);
      a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk({nm, "_early"}, 64'(out_valid), 64'(0));
      @(posedge clk);
      #1 chk({nm, "_valid"}, 64'(out_valid), 64'(1));
      chk({nm, "_res"}, 64'({co, ov, zero, sum}), 64'(exp));
   endtask

   always @(negedge clk) begin
      if (!rst_n) q.delete();
      else begin
         if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
            else begin
               chk("result", 64'({co, ov, zero, sum}), 64'(q[0]));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(ref_add(a, b, cin, sub));
      end
   end

   // unstalled sweep instances: result must emerge exactly lat(i) cycles after presentation
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         sev = cyc >= lat(i) && hv[(cyc - lat(i)) % 1024];
         chk($sformatf("sweep%0d_valid", i), 64'(sw_vld[i]), 64'(sev));
         chk($sformatf("sweep%0d_ready", i), 64'(sw_rdy[i]), 64'(1));
         if (sev) chk($sformatf("sweep%0d_res", i), 64'({sw_co[i], sw_ov[i], sw_zero[i], sw_sum[i]}),
                      64'(he[(cyc - lat(i)) % 1024]));
      end
      hv[cyc % 1024] = sv_valid;
      he[cyc % 1024] = ref_add(s_a, s_b, s_c, s_s);
   end

   initial begin
      #23;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_flags", 64'({co, ov, zero}), 64'(0));
      chk("pin_ripple", 64'(ref_add(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 1'b1, 32'h0}));
      chk("pin_sub", 64'(ref_add(32'd5, 32'd7, 1'b1, 1'b1)), 64'({3'b000, 32'hFFFFFFFE}));
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_one("ripple", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0});
      run_one("ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80000000});
      run_one("borrow", 32'd5, 32'd7, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFE});
      run_one("cin", 32'd1, 32'd2, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'd4});
      run_one("sub_eq", 32'h1234, 32'h1234, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0});
      run_one("sub_ovf", 32'h80000000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 32'h7FFFFFFF});
      // six back-to-back items must emerge on six consecutive cycles
      for (int j = 0; j < 12; j++) begin
         in_valid = j < 6;
         a = 32'h0FFF_FFFF + 32'h1000_0000 * j;
         b = 32'h2345_6789 * j;
         sub = j[0];
         cin = j[1];
         @(posedge clk);
         #1 chk($sformatf("b2b_valid%0d", j), 64'(out_valid), 64'(j >= 3 && j <= 8));
      end
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1; a = 32'hA5A5_0000 + j; b = 32'h5A5A_FFFF; cin = 1'b1; sub = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("bp_first_valid", 64'(out_valid), 64'(1));
      out_ready = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1; sub = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1 chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_held_valid", 64'(out_valid), 64'(1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      repeat (60) begin
         in_valid = 1'($urandom % 3 != 0); out_ready = 1'($urandom % 4 != 0);
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      // reset with one item at the output and three behind it
      for (int j = 0; j < 4; j++) begin
         in_valid = 1'b1; a = 32'h100 * (j + 1); b = 32'h3; cin = 1'b0; sub = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("mid_valid", 64'(out_valid), 64'(1));
      #1 rst_n = 1'b0;
      #1 chk("async_clr_valid", 64'(out_valid), 64'(0));
      chk("async_in_ready", 64'(in_ready), 64'(1));
      chk("async_outs", 64'({co, ov, zero, sum}), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1 chk("no_stale", 64'(out_valid), 64'(0));
      end
      run_one("post_rst", 32'hFF, 32'h1, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'h101});
      for (int j = 0; j < 80; j++) begin
         sv_valid = 1'($urandom % 4 != 0);
         s_a = j % 5 == 0 ? 32'hFFFFFFFF : $urandom;
         s_b = j % 7 == 0 ? 32'h1 : $urandom;
         s_c = 1'($urandom); s_s = 1'($urandom);
         @(posedge clk);
         #1;
      end
      sv_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1 chk("scoreboard_drained", 64'(q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The module SHALL have parameter CHUNK_W, default 8, meaning bits added per pipeline stage; WIDTH % CHUNK_W == 0 is required, and elaboration SHALL fail otherwise.
REQ-003 The module SHALL have derived constant STAGES = WIDTH/CHUNK_W, meaning pipeline depth and latency in cycles.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, exposed as ports clk_i and rst_ni.
REQ-005 Port clk_i: input, 1 bit, the single clock; all state on rising edge.
REQ-006 Port rst_ni: input, 1 bit, asynchronous active-low reset.
REQ-007 Port in_valid_i: input, 1 bit, operands valid.
REQ-008 Port in_ready_o: output, 1 bit, pipeline accepts operands this cycle.
REQ-009 Port a_i: input, WIDTH bits, operand A.
REQ-010 Port b_i: input, WIDTH bits, operand B.
REQ-011 Port carry_i: input, 1 bit, carry-in for add; ignored when sub_i=1.
REQ-012 Port sub_i: input, 1 bit, mode select (0 = A+B+carry_i, 1 = A-B).
REQ-013 Port out_valid_o: output, 1 bit, result valid.
REQ-014 Port out_ready_i: input, 1 bit, consumer accepts result.
REQ-015 Port sum_o: output, WIDTH bits, result.
REQ-016 Port carry_o: output, 1 bit, carry out of MSB (for sub: 1 = no borrow).
REQ-017 Port overflow_o: output, 1 bit, signed two's-complement overflow.
REQ-018 Port zero_o: output, 1 bit, sum_o == 0.

Function
REQ-019 Effective operation SHALL be A + B' + cin, with B' = sub_i ? ~B : B and cin = sub_i ? 1 : carry_i.
REQ-020 A transfer-in SHALL occur on a rising edge where in_valid_i && in_ready_o; a transfer-out SHALL occur where out_valid_o && out_ready_i.
REQ-021 Stage k (k = 0..STAGES-1) SHALL add chunk k (bits k*CHUNK_W +: CHUNK_W) of A and B' plus the carry registered from stage k-1 (cin at stage 0).
REQ-022 Each stage SHALL register its sum chunk, its carry, a valid bit, and the not-yet-added upper chunks of A and B' (operand skew); completed lower sum chunks SHALL travel with the item.
REQ-023 Latency: an item accepted at edge N SHALL appear on outputs after edge N+STAGES-1 (visible in cycle N+STAGES), given no stall.
REQ-024 Throughput: one item per cycle while out_ready_i=1.
REQ-025 advance = !out_valid_o || out_ready_i; all stage registers SHALL load only when advance=1, otherwise hold (global stall).
REQ-026 in_ready_o SHALL equal advance, combinationally.
REQ-027 Bubbles SHALL advance as invalid entries; they are not compressed during stall.
REQ-028 A stage loaded with no valid input SHALL clear its valid bit; its data content is don't-care.
REQ-029 overflow_o SHALL be (A[W-1] == B'[W-1]) && (sum_o[W-1] != A[W-1]), computed in the last stage from propagated MSBs.
REQ-030 zero_o SHALL be the NOR of the full registered sum_o.
REQ-031 While out_valid_o=1 && out_ready_i=0, sum_o, carry_o, overflow_o and zero_o SHALL hold stable.
REQ-032 STAGES=1 SHALL degenerate to a single registered adder with identical handshake behaviour.
REQ-033 Carry chain SHALL wrap modulo 2^WIDTH; the final carry appears only on carry_o.

Reset
REQ-034 On rst_ni=0, all valid bits SHALL clear immediately (asynchronous), and out_valid_o SHALL be 0, in_ready_o SHALL be 1, and sum_o, carry_o, overflow_o, zero_o SHALL read 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight items, and no partial result SHALL emerge after deassertion.
REQ-036 The first transfer-in SHALL be possible on the first rising edge after rst_ni deassertion.

Verification (WIDTH=32, CHUNK_W=8, STAGES=4 unless stated)
REQ-037 Add with full carry ripple: A=0xFFFFFFFF, B=0x00000001, carry_i=0, sub_i=0 -> 4 cycles later sum_o=0x00000000, carry_o=1, zero_o=1, overflow_o=0.
REQ-038 Signed overflow: A=0x7FFFFFFF, B=0x00000001, add -> sum_o=0x80000000, overflow_o=1, carry_o=0, zero_o=0.
REQ-039 Subtract with borrow: A=5, B=7, sub_i=1, carry_i=1 (ignored) -> sum_o=0xFFFFFFFE, carry_o=0, overflow_o=0.
REQ-040 Back-to-back then backpressure: 6 consecutive inputs with out_ready_i=1 -> 6 results on consecutive cycles, in order; dropping out_ready_i with out_valid_o=1 -> in_ready_o=0 and outputs frozen until out_ready_i=1.
REQ-041 Reset mid-flight: assert rst_ni=0 with 3 items in flight -> out_valid_o=0 asynchronously; after release, no stale outputs and the next input yields its correct result at latency 4.
REQ-042 Parameter sweep: CHUNK_W in {1, 4, 32}, random operands and modes -> results match the reference model A+B'+cin, with latency = STAGES.
